// File: rtl/obstacle_pkg.sv
// obstacle_pkg
//   Shared definitions for the obstacle generator and its consumers.
//   Obstacle type encoding, beat field slices and default geometry constants.
package obstacle_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'b000,
    LOW    = 3'b001,
    HIGH   = 3'b010,
    MID    = 3'b011,
    TRAIN  = 3'b100,
    RAMP   = 3'b101,
    MOVING = 3'b110
  } obstacle_t;

  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 13;
  localparam int LANE_MSB = 12;
  localparam int LANE_LSB = 11;
  localparam int DEPTH_W  = 11;

  localparam int HALF_BLOCK       = 64;
  localparam int TRAIN_HEIGHT_DEF = 64;
  localparam int JUMP_CLEAR_DEF   = 32;
  localparam int RAMP_HEIGHT_DEF  = 32;

endpackage

// File: rtl/obstacle_hit_eval.sv
// obstacle_hit_eval
//   Stage-2 classifier. Classifies one matched obstacle against the latched
//   player pose and registers the verdict for the accumulator.
//   The same classification is also exposed combinationally (la_*) so the
//   reporting logic can fold in a beat that is still sitting in stage 1.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   clr                 drop the registered verdict (new frame)
//   in_valid, in_type   matched beat from stage 1 and its obstacle type
//   height, ducking     latched player pose
//   la_*                combinational verdict for the current input
//   hit, hit_type       registered hit flag and the type that caused it
//   support_valid/_h    registered support surface under the player
module obstacle_hit_eval
  import obstacle_pkg::*;
#(
  parameter int JUMP_CLEAR   = JUMP_CLEAR_DEF,
  parameter int TRAIN_HEIGHT = TRAIN_HEIGHT_DEF,
  parameter int RAMP_HEIGHT  = RAMP_HEIGHT_DEF,
  parameter int HEIGHT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [2:0]          in_type,
  input  logic [HEIGHT_W-1:0] height,
  input  logic                ducking,
  output logic                la_hit,
  output logic                la_support_valid,
  output logic [HEIGHT_W-1:0] la_support_h,
  output logic                hit,
  output logic [2:0]          hit_type,
  output logic                support_valid,
  output logic [HEIGHT_W-1:0] support_h
);

  localparam logic [HEIGHT_W-1:0] JUMP_H  = HEIGHT_W'(JUMP_CLEAR);
  localparam logic [HEIGHT_W-1:0] TRAIN_H = HEIGHT_W'(TRAIN_HEIGHT);
  localparam logic [HEIGHT_W-1:0] RAMP_H  = HEIGHT_W'(RAMP_HEIGHT);

  always_comb begin
    la_hit           = 1'b0;
    la_support_valid = 1'b0;
    la_support_h     = '0;
    if (in_valid) begin
      case (in_type)
        LOW:  la_hit = (height < JUMP_H);
        HIGH: la_hit = !ducking;
        MID:  la_hit = !ducking && (height < JUMP_H);
        TRAIN, MOVING: begin
          // standing on the roof turns the car into a support surface
          if (height >= TRAIN_H) begin
            la_support_valid = 1'b1;
            la_support_h     = TRAIN_H;
          end else begin
            la_hit = 1'b1;
          end
        end
        RAMP: begin
          la_support_valid = 1'b1;
          la_support_h     = RAMP_H;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hit           <= 1'b0;
      hit_type      <= 3'b000;
      support_valid <= 1'b0;
      support_h     <= '0;
    end else begin
      hit           <= la_hit;
      hit_type      <= in_type;
      support_valid <= la_support_valid;
      support_h     <= la_support_h;
    end
  end

endmodule

// File: rtl/obstacle_collision_detector.sv
// obstacle_collision_detector
//   Consumes the obstacle generator stream for one frame, keeps first-row
//   obstacles in the player's lane, classifies them against the pose latched
//   at frame_start and reports one result per frame.
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   frame_start                 start of frame; latches the player pose
//   player_lane/height/ducking  player pose
//   obs_valid/first_row/data    obstacle stream beat ({type, lane, depth})
//   obs_done                    generator end of frame (rising edge used)
//   result_valid                one-cycle pulse with the frame result
//   collision, collision_type   any hit / type of the nearest hit
//   hit_count                   hits in the frame, saturating at 3
//   support_height              highest support surface under the player
//
//   state   | meaning
//   IDLE    | waiting for frame_start; beats ignored
//   COLLECT | accepting beats until obs_done rises
//   DRAIN   | two cycles; beats still accepted, pipeline flushing
//   REPORT  | publish result, pulse result_valid
module obstacle_collision_detector
  import obstacle_pkg::*;
#(
  parameter int JUMP_CLEAR   = JUMP_CLEAR_DEF,
  parameter int TRAIN_HEIGHT = TRAIN_HEIGHT_DEF,
  parameter int RAMP_HEIGHT  = RAMP_HEIGHT_DEF,
  parameter int HEIGHT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [1:0]          player_lane,
  input  logic [HEIGHT_W-1:0] player_height,
  input  logic                player_ducking,
  input  logic                obs_valid,
  input  logic                obs_first_row,
  input  logic [15:0]         obs_data,
  input  logic                obs_done,
  output logic                result_valid,
  output logic                collision,
  output logic [2:0]          collision_type,
  output logic [1:0]          hit_count,
  output logic [HEIGHT_W-1:0] support_height
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] REPORT  = 2'd3;

  typedef struct packed {
    logic [1:0]          cnt;
    logic [2:0]          typ;
    logic [HEIGHT_W-1:0] sup;
  } acc_t;

  // Hits arrive nearest-first, so the type is only taken on the first hit.
  function automatic acc_t fold(input acc_t a, input logic hit_in,
                                input logic [2:0] t, input logic sv,
                                input logic [HEIGHT_W-1:0] sh);
    acc_t r;
    r = a;
    if (hit_in) begin
      if (a.cnt == 2'd0) r.typ = t;
      if (a.cnt != 2'd3) r.cnt = a.cnt + 2'd1;
    end
    if (sv && (sh > a.sup)) r.sup = sh;
    return r;
  endfunction

  logic [1:0]          state;
  logic                drain_cnt;
  logic                done_q;
  logic [1:0]          lane_q;
  logic [HEIGHT_W-1:0] height_q;
  logic                duck_q;

  logic                s1_valid;
  logic [2:0]          s1_type;

  logic                la_hit, la_sv;
  logic [HEIGHT_W-1:0] la_sh;
  logic                s2_hit, s2_sv;
  logic [2:0]          s2_type;
  logic [HEIGHT_W-1:0] s2_sh;

  acc_t acc, acc_s2, acc_all;

  logic [2:0] beat_type;
  logic [1:0] beat_lane;
  logic       beat_match;
  logic       accepting;
  logic       done_rise;

  // Depth only travels on the bus for debug; classification never uses it.
  logic unused_depth;
  assign unused_depth = ^obs_data[DEPTH_W-1:0];

  assign beat_type  = obs_data[TYPE_MSB:TYPE_LSB];
  assign beat_lane  = obs_data[LANE_MSB:LANE_LSB];
  assign accepting  = (state == COLLECT) || (state == DRAIN);
  assign beat_match = accepting && obs_valid && obs_first_row &&
                      (beat_lane == lane_q) && (beat_type != NONE);
  assign done_rise  = obs_done && !done_q;

  // acc_s2 includes the beat in stage 2; acc_all also folds in stage 1 so
  // beats accepted late in DRAIN still make it into the report.
  assign acc_s2  = fold(acc, s2_hit, s2_type, s2_sv, s2_sh);
  assign acc_all = fold(acc_s2, la_hit, s1_type, la_sv, la_sh);

  obstacle_hit_eval #(
    .JUMP_CLEAR  (JUMP_CLEAR),
    .TRAIN_HEIGHT(TRAIN_HEIGHT),
    .RAMP_HEIGHT (RAMP_HEIGHT),
    .HEIGHT_W    (HEIGHT_W)
  ) u_hit_eval (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (frame_start),
    .in_valid        (s1_valid),
    .in_type         (s1_type),
    .height          (height_q),
    .ducking         (duck_q),
    .la_hit          (la_hit),
    .la_support_valid(la_sv),
    .la_support_h    (la_sh),
    .hit             (s2_hit),
    .hit_type        (s2_type),
    .support_valid   (s2_sv),
    .support_h       (s2_sh)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      drain_cnt      <= 1'b0;
      done_q         <= 1'b0;
      lane_q         <= 2'd0;
      height_q       <= '0;
      duck_q         <= 1'b0;
      s1_valid       <= 1'b0;
      s1_type        <= 3'b000;
      acc            <= '0;
      result_valid   <= 1'b0;
      collision      <= 1'b0;
      collision_type <= 3'b000;
      hit_count      <= 2'd0;
      support_height <= '0;
    end else begin
      result_valid <= 1'b0;
      done_q       <= obs_done;
      s1_type      <= beat_type;
      if (frame_start) begin
        // restart: whatever was in flight belongs to the abandoned frame
        state     <= COLLECT;
        drain_cnt <= 1'b0;
        lane_q    <= player_lane;
        height_q  <= player_height;
        duck_q    <= player_ducking;
        s1_valid  <= 1'b0;
        acc       <= '0;
      end else begin
        s1_valid <= beat_match;
        acc      <= acc_s2;
        case (state)
          COLLECT: begin
            if (done_rise) begin
              state     <= DRAIN;
              drain_cnt <= 1'b0;
            end
          end
          DRAIN: begin
            if (drain_cnt) state <= REPORT;
            drain_cnt <= 1'b1;
          end
          REPORT: begin
            state          <= IDLE;
            result_valid   <= 1'b1;
            collision      <= (acc_all.cnt != 2'd0);
            collision_type <= acc_all.typ;
            hit_count      <= acc_all.cnt;
            support_height <= acc_all.sup;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_collision_detector.sv
module tb_obstacle_collision_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [1:0] player_lane;
  logic [7:0] player_height;
  logic       player_ducking;
  logic       obs_valid;
  logic       obs_first_row;
  logic [15:0] obs_data;
  logic       obs_done;
  logic       result_valid;
  logic       collision;
  logic [2:0] collision_type;
  logic [1:0] hit_count;
  logic [7:0] support_height;

  typedef struct {
    logic       col;
    logic [2:0] typ;
    logic [1:0] cnt;
    logic [7:0] sup;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  obstacle_collision_detector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .player_lane   (player_lane),
    .player_height (player_height),
    .player_ducking(player_ducking),
    .obs_valid     (obs_valid),
    .obs_first_row (obs_first_row),
    .obs_data      (obs_data),
    .obs_done      (obs_done),
    .result_valid  (result_valid),
    .collision     (collision),
    .collision_type(collision_type),
    .hit_count     (hit_count),
    .support_height(support_height)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: compare every result pulse against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("collision", int'(collision), int'(e.col));
          chk("collision_type", int'(collision_type), int'(e.typ));
          chk("hit_count", int'(hit_count), int'(e.cnt));
          chk("support_height", int'(support_height), int'(e.sup));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] ln, input logic [7:0] h, input logic d);
    frame_start = 1'b1; player_lane = ln; player_height = h; player_ducking = d;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic beat(input logic [2:0] t, input logic [1:0] ln,
                      input logic [10:0] dep, input logic fr, input logic dn);
    obs_valid = 1'b1; obs_first_row = fr; obs_data = {t, ln, dep}; obs_done = dn;
    tick();
    obs_valid = 1'b0; obs_first_row = 1'b0; obs_done = 1'b0;
  endtask

  task automatic expect_res(input logic c, input logic [2:0] t,
                            input logic [1:0] n, input logic [7:0] s);
    exp_t e;
    e.col = c; e.typ = t; e.cnt = n; e.sup = s;
    exp_q.push_back(e);
  endtask

  task automatic done_pulse();
    obs_done = 1'b1;
    tick();
    obs_done = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("result_timeout", exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; player_lane = 2'd0; player_height = 8'd0;
    player_ducking = 1'b0; obs_valid = 1'b0; obs_first_row = 1'b0;
    obs_data = 16'h0; obs_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_collision", int'(collision), 0);
    chk("reset_type", int'(collision_type), 0);
    chk("reset_count", int'(hit_count), 0);
    chk("reset_support", int'(support_height), 0);

    // 1: beat in IDLE ignored; clean frame
    beat(3'b001, 2'd0, 11'd5, 1'b1, 1'b0);
    start(2'd1, 8'd0, 1'b0);
    beat(3'b001, 2'd0, 11'd10, 1'b1, 1'b0);
    beat(3'b010, 2'd2, 11'd20, 1'b1, 1'b0);
    beat(3'b001, 2'd1, 11'd30, 1'b0, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd0);
    done_pulse();
    wait_result();

    // 2: low barrier, then cleared by jump
    start(2'd1, 8'd0, 1'b0);
    beat(3'b001, 2'd1, 11'd40, 1'b1, 1'b0);
    expect_res(1'b1, 3'b001, 2'd1, 8'd0);
    done_pulse(); wait_result();
    start(2'd1, 8'd32, 1'b0);
    beat(3'b001, 2'd1, 11'd40, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd0);
    done_pulse(); wait_result();

    // 3: duck / mid
    start(2'd1, 8'd0, 1'b1);
    beat(3'b010, 2'd1, 11'd40, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd0);
    done_pulse(); wait_result();
    start(2'd1, 8'd10, 1'b0);
    beat(3'b011, 2'd1, 11'd40, 1'b1, 1'b0);
    expect_res(1'b1, 3'b011, 2'd1, 8'd0);
    done_pulse(); wait_result();
    start(2'd1, 8'd40, 1'b0);
    beat(3'b011, 2'd1, 11'd40, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd0);
    done_pulse(); wait_result();

    // 4: train roof and ramp
    start(2'd2, 8'd63, 1'b0);
    beat(3'b100, 2'd2, 11'd50, 1'b1, 1'b0);
    expect_res(1'b1, 3'b100, 2'd1, 8'd0);
    done_pulse(); wait_result();
    start(2'd2, 8'd64, 1'b0);
    beat(3'b100, 2'd2, 11'd50, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd64);
    done_pulse(); wait_result();
    start(2'd0, 8'd64, 1'b0);
    beat(3'b101, 2'd0, 11'd30, 1'b1, 1'b0);
    beat(3'b110, 2'd0, 11'd60, 1'b1, 1'b0);
    beat(3'b111, 2'd0, 11'd70, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd64);
    done_pulse(); wait_result();
    start(2'd0, 8'd0, 1'b0);
    beat(3'b101, 2'd0, 11'd30, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd32);
    done_pulse(); wait_result();

    // 5: multi-hit ordering and saturation
    start(2'd1, 8'd0, 1'b0);
    beat(3'b010, 2'd1, 11'd20, 1'b1, 1'b0);
    beat(3'b001, 2'd1, 11'd60, 1'b1, 1'b0);
    beat(3'b001, 2'd1, 11'd80, 1'b1, 1'b0);
    beat(3'b011, 2'd1, 11'd90, 1'b1, 1'b0);
    beat(3'b100, 2'd1, 11'd100, 1'b1, 1'b0);
    beat(3'b110, 2'd1, 11'd110, 1'b1, 1'b0);
    expect_res(1'b1, 3'b010, 2'd3, 8'd0);
    done_pulse(); wait_result();

    // 6a: reset during DRAIN; previous outputs were a collision
    start(2'd1, 8'd0, 1'b0);
    beat(3'b001, 2'd1, 11'd20, 1'b1, 1'b0);
    done_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rst_drain_collision", int'(collision), 0);
    chk("rst_drain_type", int'(collision_type), 0);
    chk("rst_drain_count", int'(hit_count), 0);

    // 6b: frame restart after a hit drops that hit
    start(2'd1, 8'd0, 1'b0);
    beat(3'b001, 2'd1, 11'd20, 1'b1, 1'b0);
    start(2'd1, 8'd40, 1'b0);
    beat(3'b001, 2'd1, 11'd20, 1'b1, 1'b0);
    expect_res(1'b0, 3'b000, 2'd0, 8'd0);
    tick(); tick();
    done_pulse(); wait_result();

    // 6c: beat coincident with done
    start(2'd1, 8'd0, 1'b0);
    beat(3'b010, 2'd1, 11'd20, 1'b1, 1'b1);
    expect_res(1'b1, 3'b010, 2'd1, 8'd0);
    wait_result();

    // beats in both DRAIN cycles are still counted
    start(2'd1, 8'd0, 1'b0);
    done_pulse();
    beat(3'b010, 2'd1, 11'd20, 1'b1, 1'b0);
    beat(3'b100, 2'd1, 11'd30, 1'b1, 1'b0);
    expect_res(1'b1, 3'b010, 2'd2, 8'd0);
    wait_result();

    for (int i = 0; i < 4; i++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
